// File: rtl/maze_pkg.sv
// Shared types for the maze solver datapath.
// Move encoding and path streamer state machine.
package maze_pkg;

    typedef logic [1:0] move_t;

    localparam move_t MOVE_UP    = 2'd0;
    localparam move_t MOVE_RIGHT = 2'd1;
    localparam move_t MOVE_DOWN  = 2'd2;
    localparam move_t MOVE_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DONE
    } stream_state_e;

endpackage

// File: rtl/move_select.sv
// Indexed mux picking one move out of a flat move vector.
// Out-of-range indices return zero.
module move_select
    import maze_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int MOVE_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic [DEPTH*MOVE_W-1:0] flat_i,
    input  logic [CNT_W:0]          idx_i,
    output logic [MOVE_W-1:0]       move_o
);

    localparam int IW = CNT_W + 1;

    // Compare the index against every slot and forward the match.
    always_comb begin
        move_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx_i == IW'(i)) begin
                move_o = flat_i[i*MOVE_W +: MOVE_W];
            end
        end
    end

endmodule

// File: rtl/path_streamer.sv
// Snapshots the move stack on load and replays it one move
// per valid/ready handshake, forward or reversed.
module path_streamer
    import maze_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int MOVE_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    reverse,
    input  logic                    flush,
    input  logic [DEPTH*MOVE_W-1:0] stack_data,
    input  logic [CNT_W-1:0]        stack_count,
    input  logic                    out_ready,
    output logic [MOVE_W-1:0]       move_out,
    output logic                    move_valid,
    output logic                    move_last,
    output logic                    busy,
    output logic                    finished,
    output logic                    overflow
);

    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    stream_state_e             state_q, state_d;
    logic [DEPTH*MOVE_W-1:0]   snap_q, snap_d;
    logic                      rev_q, rev_d;
    logic [CNT_W:0]            idx_q, idx_d;
    logic [CNT_W:0]            rem_q, rem_d;
    logic                      ovf_q, ovf_d;
    logic [CNT_W:0]            cnt_ext;
    logic [MOVE_W-1:0]         sel_move;

    assign cnt_ext = {1'b0, stack_count};

    move_select #(
        .DEPTH  (DEPTH),
        .MOVE_W (MOVE_W),
        .CNT_W  (CNT_W)
    ) u_sel (
        .flat_i (snap_q),
        .idx_i  (idx_q),
        .move_o (sel_move)
    );

    assign move_valid = (state_q == ST_STREAM);
    assign move_out   = move_valid ? sel_move : '0;
    assign move_last  = move_valid && (rem_q == (CNT_W+1)'(1));
    assign busy       = (state_q == ST_LOAD) || move_valid;
    assign finished   = (state_q == ST_DONE);
    assign overflow   = ovf_q;

    // Next-state logic; flush beats load and every state transition.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        rev_d   = rev_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        snap_d  = stack_data;
                        rev_d   = reverse;
                        ovf_d   = (cnt_ext > DEPTH_C);
                        rem_d   = ovf_d ? DEPTH_C : cnt_ext;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (rem_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = rev_q ? rem_q - 1'b1 : '0;
                        state_d = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        rem_d = rem_q - 1'b1;
                        if (move_last) begin
                            state_d = ST_DONE;
                        end else if (rev_q) begin
                            idx_d = idx_q - 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, snapshot and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            rev_q   <= 1'b0;
            idx_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            rev_q   <= rev_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_path_streamer.sv
// Directed bench for path_streamer: forward, reverse,
// empty, overflow, flush, reset and snapshot isolation.
module tb_path_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        reverse = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] stack_data = '0;
    logic [7:0]  stack_count = '0;
    logic        out_ready = 1'b0;

    logic [1:0]  move_out, move_out_s;
    logic        move_valid, move_valid_s;
    logic        move_last, move_last_s;
    logic        busy, busy_s;
    logic        finished, finished_s;
    logic        overflow, overflow_s;

    int checks = 0;
    int failures = 0;

    path_streamer #(.DEPTH(8), .MOVE_W(2), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .reverse     (reverse),
        .flush       (flush),
        .stack_data  (stack_data),
        .stack_count (stack_count),
        .out_ready   (out_ready),
        .move_out    (move_out),
        .move_valid  (move_valid),
        .move_last   (move_last),
        .busy        (busy),
        .finished    (finished),
        .overflow    (overflow)
    );

    path_streamer #(.DEPTH(4), .MOVE_W(2), .CNT_W(8)) dut_s (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .reverse     (reverse),
        .flush       (flush),
        .stack_data  (stack_data[7:0]),
        .stack_count (stack_count),
        .out_ready   (out_ready),
        .move_out    (move_out_s),
        .move_valid  (move_valid_s),
        .move_last   (move_last_s),
        .busy        (busy_s),
        .finished    (finished_s),
        .overflow    (overflow_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start(input logic [15:0] d, input logic [7:0] c,
                         input logic r);
        stack_data  = d;
        stack_count = c;
        reverse     = r;
        load        = 1'b1;
        tick();
        load        = 1'b0;
    endtask

    int n_beats;
    logic seen_fin;

    initial begin
        #2;
        chk("rst_valid", move_valid, 0);
        chk("rst_move", move_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fin", finished, 0);
        chk("rst_ovf", overflow, 0);
        tick();
        rst = 1'b0;
        tick();

        // forward: UP, RIGHT, DOWN
        out_ready = 1'b1;
        start(16'h0024, 8'd3, 1'b0);
        chk("fwd_load_busy", busy, 1);
        chk("fwd_load_valid", move_valid, 0);
        tick();
        chk("fwd_b0", {move_valid, move_last, move_out}, {2'b10, 2'd0});
        tick();
        chk("fwd_b1", {move_valid, move_last, move_out}, {2'b10, 2'd1});
        tick();
        chk("fwd_b2", {move_valid, move_last, move_out}, {2'b11, 2'd2});
        tick();
        chk("fwd_done", {finished, move_valid, busy}, 3'b100);
        tick();
        chk("fwd_idle", {finished, busy}, 2'b00);

        // reverse with backpressure: DOWN x3, RIGHT, UP
        out_ready = 1'b0;
        start(16'h0024, 8'd3, 1'b1);
        tick();
        chk("rev_hold0", {move_valid, move_last, move_out}, {2'b10, 2'd2});
        tick();
        chk("rev_hold1", {move_valid, move_last, move_out}, {2'b10, 2'd2});
        tick();
        chk("rev_hold2", {move_valid, move_last, move_out}, {2'b10, 2'd2});
        out_ready = 1'b1;
        tick();
        chk("rev_b1", {move_valid, move_last, move_out}, {2'b10, 2'd1});
        tick();
        chk("rev_b2", {move_valid, move_last, move_out}, {2'b11, 2'd0});
        tick();
        chk("rev_done", {finished, move_valid}, 2'b10);
        tick();

        // empty stack
        start(16'h0024, 8'd0, 1'b0);
        chk("emp_busy", {busy, move_valid, finished}, 3'b100);
        tick();
        chk("emp_done", {busy, move_valid, finished}, 3'b001);
        tick();
        chk("emp_idle", {busy, move_valid, finished}, 3'b000);

        // overflow on the 4-deep instance: entries 0,1,2,3
        start(16'h00E4, 8'd6, 1'b0);
        chk("ovf_set", overflow_s, 1);
        chk("ovf_big_clear", overflow, 0);
        n_beats  = 0;
        seen_fin = 1'b0;
        for (int c = 0; c < 20 && !seen_fin; c++) begin
            tick();
            if (move_valid_s) begin
                chk("ovf_move", move_out_s, n_beats[1:0]);
                chk("ovf_last", move_last_s, (n_beats == 3) ? 1 : 0);
                n_beats++;
            end
            seen_fin = finished_s;
        end
        chk("ovf_fin_seen", seen_fin, 1);
        chk("ovf_beats", n_beats, 4);
        chk("ovf_hold_fin", overflow_s, 1);
        tick();
        chk("ovf_hold_idle", overflow_s, 1);
        settle(4);
        start(16'h00E4, 8'd2, 1'b0);
        chk("ovf_clear", overflow_s, 0);
        settle(6);

        // flush after two accepted moves: entries 0,1,2,3,0
        start(16'h00E4, 8'd5, 1'b0);
        tick();
        chk("fl_b0", move_out, 0);
        tick();
        chk("fl_b1", move_out, 1);
        tick();
        chk("fl_b2", {move_valid, move_out}, {1'b1, 2'd2});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_idle", {move_valid, busy, finished}, 3'b000);
        tick();
        chk("fl_nofin", {move_valid, busy, finished}, 3'b000);
        start(16'h00E4, 8'd5, 1'b0);
        tick();
        chk("fl_restart", {move_valid, move_out}, {1'b1, 2'd0});
        settle(8);

        // snapshot isolation: entries LEFT, DOWN, RIGHT
        start(16'h001B, 8'd3, 1'b0);
        stack_data = 16'h0000;
        tick();
        chk("iso_b0", move_out, 3);
        tick();
        chk("iso_b1", move_out, 2);
        tick();
        chk("iso_b2", {move_last, move_out}, {1'b1, 2'd1});
        settle(3);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        start(16'h001B, 8'd3, 1'b0);
        tick();
        chk("rs_pre", {move_valid, move_out}, {1'b1, 2'd3});
        #2;
        rst = 1'b1;
        #1;
        chk("rs_async", {move_valid, busy, move_out, finished}, 5'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("rs_idle", {move_valid, busy, finished, overflow}, 4'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
